noc_vc_controller: RTL and testbench

- Controller end of the Noc_control_interface handshake, one instance per router output port.
- Owns the per-VC allocation state: grants a VC to the upstream requester and tracks packet boundaries from start_of_packet to end_of_packet.
- Releases the VC on free.
- Gates each grant on downstream buffer credits, which it counts per VC.

---
 rtl/noc_vc_controller_pkg.sv | 18 +
 rtl/noc_control_interface.sv | 20 ++
 rtl/noc_vc_controller_slot.sv | 86 ++++++++
 rtl/noc_vc_controller.sv | 44 ++++
 tb/tb_noc_vc_controller.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_vc_controller_pkg.sv
// Shared NoC parameters and types for the virtual-channel controller.
package Noc_parameters;

    localparam int Noc_VC_Channel = 4;

    typedef enum logic [1:0] {
        IDLE,
        GRANTED,
        ACTIVE,
        DONE
    } vc_state_e;

    // Bits needed to hold a credit count from 0 up to and including depth.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/noc_control_interface.sv
// Handshake bundle between an upstream requester and a per-port VC controller.
interface Noc_control_interface #(
    parameter int Channel = Noc_parameters::Noc_VC_Channel
);
    logic [Channel-1:0] request;
    logic [Channel-1:0] free;
    logic [Channel-1:0] start_of_packet;
    logic [Channel-1:0] end_of_packet;
    logic [Channel-1:0] grant;

    modport controller (
        input  request, free, start_of_packet, end_of_packet,
        output grant
    );

    modport requester (
        output request, free, start_of_packet, end_of_packet,
        input  grant
    );
endinterface

// File: rtl/noc_vc_controller_slot.sv
// One virtual channel: allocation FSM plus downstream credit counter.
module noc_vc_slot
    import Noc_parameters::*;
#(
    parameter  int BufferDepth = 4,
    localparam int CreditWidth = credit_width(BufferDepth)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   request_i,
    input  logic                   free_i,
    input  logic                   sop_i,
    input  logic                   eop_i,
    input  logic                   flit_sent_i,
    input  logic                   credit_return_i,
    output logic                   grant_o,
    output logic                   vc_active_o,
    output logic                   credit_avail_o,
    output logic [CreditWidth-1:0] credit_count_o,
    output logic                   proto_error_o
);

    localparam logic [CreditWidth-1:0] CreditMax = CreditWidth'(BufferDepth);

    vc_state_e              state_q, state_d;
    logic [CreditWidth-1:0] count_q, count_d;
    logic                   err_q, err_d;

    always_comb begin
        // NOTE: every next-state value is defaulted to its current value first so no path can infer a latch.
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                // Credits gate only this transition; an owned VC is never revoked.
                if (request_i && count_q != '0) state_d = GRANTED;
            end
            GRANTED: begin
                if (free_i) err_d = 1'b1;
                if (sop_i && eop_i)  state_d = DONE;
                else if (sop_i)      state_d = ACTIVE;
                else if (eop_i)      err_d   = 1'b1;
                else if (!request_i) state_d = IDLE;
            end
            ACTIVE: begin
                if (sop_i || free_i) err_d = 1'b1;
                if (eop_i) state_d = DONE;
            end
            DONE: begin
                if (sop_i)  err_d   = 1'b1;
                if (free_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (flit_sent_i && !credit_return_i) begin
            if (count_q == '0) err_d   = 1'b1;
            else               count_d = count_q - CreditWidth'(1);
        end else if (credit_return_i && !flit_sent_i) begin
            if (count_q == CreditMax) err_d   = 1'b1;
            else                      count_d = count_q + CreditWidth'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= CreditMax;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign grant_o        = (state_q != IDLE);
    assign vc_active_o    = (state_q == ACTIVE);
    assign credit_avail_o = (count_q != '0);
    assign credit_count_o = count_q;
    assign proto_error_o  = err_q;

endmodule

// File: rtl/noc_vc_controller.sv
// Per-output-port VC controller: one independent allocation slot per virtual channel.
module noc_vc_controller
    import Noc_parameters::*;
#(
    parameter  int Channel     = Noc_VC_Channel,
    parameter  int BufferDepth = 4,
    localparam int CreditWidth = credit_width(BufferDepth)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    Noc_control_interface.controller       ctrl,
    input  logic [Channel-1:0]             flit_sent,
    input  logic [Channel-1:0]             credit_return,
    output logic [Channel-1:0]             credit_avail,
    output logic [Channel-1:0]             vc_active,
    output logic [Channel*CreditWidth-1:0] credit_count,
    output logic [Channel-1:0]             proto_error
);

    logic [Channel-1:0] grant_w;

    for (genvar i = 0; i < Channel; i++) begin : g_slot
        noc_vc_slot #(
            .BufferDepth(BufferDepth)
        ) u_slot (
            .clk            (clk),
            .rst_n          (rst_n),
            .request_i      (ctrl.request[i]),
            .free_i         (ctrl.free[i]),
            .sop_i          (ctrl.start_of_packet[i]),
            .eop_i          (ctrl.end_of_packet[i]),
            .flit_sent_i    (flit_sent[i]),
            .credit_return_i(credit_return[i]),
            .grant_o        (grant_w[i]),
            .vc_active_o    (vc_active[i]),
            .credit_avail_o (credit_avail[i]),
            .credit_count_o (credit_count[i*CreditWidth +: CreditWidth]),
            .proto_error_o  (proto_error[i])
        );
    end

    assign ctrl.grant = grant_w;

endmodule

// File: tb/tb_noc_vc_controller.sv
// Directed and randomized checks of noc_vc_controller against a packet-level reference model.
module tb_noc_vc_controller;

    localparam int NCH   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    flit_sent;
    logic [NCH-1:0]    credit_return;
    logic [NCH-1:0]    credit_avail;
    logic [NCH-1:0]    vc_active;
    logic [NCH*CW-1:0] credit_count;
    logic [NCH-1:0]    proto_error;

    Noc_control_interface #(.Channel(NCH)) ctrl_if ();

    noc_vc_controller #(
        .Channel    (NCH),
        .BufferDepth(DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ctrl         (ctrl_if),
        .flit_sent    (flit_sent),
        .credit_return(credit_return),
        .credit_avail (credit_avail),
        .vc_active    (vc_active),
        .credit_count (credit_count),
        .proto_error  (proto_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: a VC is owned from grant to free, carries a packet
    // between SOP and EOP, and has finished its packet once EOP is seen.
    int cred  [NCH];
    bit owned [NCH];
    bit in_pkt[NCH];
    bit ended [NCH];
    bit err   [NCH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < NCH; i++) begin
            bit rq, fr, sp, ep, fs, cr;
            int c0;
            rq = ctrl_if.request[i];
            fr = ctrl_if.free[i];
            sp = ctrl_if.start_of_packet[i];
            ep = ctrl_if.end_of_packet[i];
            fs = flit_sent[i];
            cr = credit_return[i];
            if (!rst_n) begin
                cred[i] = DEPTH; owned[i] = 0; in_pkt[i] = 0; ended[i] = 0; err[i] = 0;
                continue;
            end
            c0 = cred[i];
            if (fs && !cr) begin
                if (cred[i] == 0) err[i] = 1; else cred[i] = cred[i] - 1;
            end else if (cr && !fs) begin
                if (cred[i] == DEPTH) err[i] = 1; else cred[i] = cred[i] + 1;
            end
            if (!owned[i]) begin
                if (rq && c0 > 0) owned[i] = 1;
            end else if (in_pkt[i]) begin
                if (sp || fr) err[i] = 1;
                if (ep) begin in_pkt[i] = 0; ended[i] = 1; end
            end else if (ended[i]) begin
                if (sp) err[i] = 1;
                if (fr) begin owned[i] = 0; ended[i] = 0; end
            end else begin
                if (fr) err[i] = 1;
                if (sp && ep)  ended[i]  = 1;
                else if (sp)   in_pkt[i] = 1;
                else if (ep)   err[i]    = 1;
                else if (!rq)  owned[i]  = 0;
            end
        end
    endtask

    task automatic compare_all();
        logic [NCH-1:0]    e_grant, e_act, e_avail, e_err;
        logic [NCH*CW-1:0] e_cc;
        for (int i = 0; i < NCH; i++) begin
            e_grant[i]         = owned[i];
            e_act[i]           = in_pkt[i];
            e_avail[i]         = (cred[i] > 0);
            e_err[i]           = err[i];
            e_cc[i*CW +: CW]   = CW'(cred[i]);
        end
        check($sformatf("grant@%0d", cyc),        32'(ctrl_if.grant), 32'(e_grant));
        check($sformatf("vc_active@%0d", cyc),    32'(vc_active),     32'(e_act));
        check($sformatf("credit_avail@%0d", cyc), 32'(credit_avail),  32'(e_avail));
        check($sformatf("credit_count@%0d", cyc), 32'(credit_count),  32'(e_cc));
        check($sformatf("proto_error@%0d", cyc),  32'(proto_error),   32'(e_err));
    endtask

    // One clock: model follows the edge, outputs are sampled on the falling edge.
    task automatic cycle(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            cyc++;
            compare_all();
        end
    endtask

    task automatic clear_inputs();
        ctrl_if.request         = '0;
        ctrl_if.free            = '0;
        ctrl_if.start_of_packet = '0;
        ctrl_if.end_of_packet   = '0;
        flit_sent               = '0;
        credit_return           = '0;
    endtask

    function automatic logic [CW-1:0] cc(input int vc);
        logic [NCH*CW-1:0] v;
        v = credit_count;
        return v[vc*CW +: CW];
    endfunction

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        cycle(2);
        rst_n = 1'b1;
        check("reset_grant", 32'(ctrl_if.grant), 32'h0);
        check("reset_avail", 32'(credit_avail), 32'hF);
        check("reset_err",   32'(proto_error), 32'h0);

        // Grant latency of one cycle on VC0.
        ctrl_if.request[0] = 1'b1;
        cycle();
        check("vc0_grant_1cyc", 32'(ctrl_if.grant[0]), 32'h1);
        check("vc0_credit",     32'(cc(0)), 32'd4);
        check("avail_all",      32'(credit_avail), 32'hF);
        ctrl_if.request[0] = 1'b0;
        cycle();
        check("vc0_withdraw", 32'(ctrl_if.grant[0]), 32'h0);

        // Full packet on VC1 with three flits.
        ctrl_if.request[1] = 1'b1;
        cycle();
        ctrl_if.start_of_packet[1] = 1'b1;
        cycle();
        ctrl_if.start_of_packet[1] = 1'b0;
        check("vc1_active_after_sop", 32'(vc_active[1]), 32'h1);
        flit_sent[1] = 1'b1;
        cycle(3);
        flit_sent[1] = 1'b0;
        check("vc1_credit_1", 32'(cc(1)), 32'd1);
        check("vc1_active_mid", 32'(vc_active[1]), 32'h1);
        ctrl_if.end_of_packet[1] = 1'b1;
        cycle();
        ctrl_if.end_of_packet[1] = 1'b0;
        check("vc1_active_after_eop", 32'(vc_active[1]), 32'h0);
        check("vc1_grant_done", 32'(ctrl_if.grant[1]), 32'h1);
        ctrl_if.free[1]    = 1'b1;
        ctrl_if.request[1] = 1'b0;
        cycle();
        ctrl_if.free[1] = 1'b0;
        check("vc1_grant_after_free", 32'(ctrl_if.grant[1]), 32'h0);

        // VC2 starved of credit, then one credit returned.
        flit_sent[2] = 1'b1;
        cycle(4);
        flit_sent[2] = 1'b0;
        check("vc2_no_avail", 32'(credit_avail[2]), 32'h0);
        ctrl_if.request[2] = 1'b1;
        cycle(2);
        check("vc2_no_grant", 32'(ctrl_if.grant[2]), 32'h0);
        credit_return[2] = 1'b1;
        cycle();
        credit_return[2] = 1'b0;
        check("vc2_count_1", 32'(cc(2)), 32'd1);
        check("vc2_still_no_grant", 32'(ctrl_if.grant[2]), 32'h0);
        cycle();
        check("vc2_grant", 32'(ctrl_if.grant[2]), 32'h1);
        ctrl_if.request[2] = 1'b0;
        cycle();

        // Single-flit packet and simultaneous send/return on VC0.
        ctrl_if.request[0] = 1'b1;
        cycle();
        ctrl_if.start_of_packet[0] = 1'b1;
        ctrl_if.end_of_packet[0]   = 1'b1;
        cycle();
        ctrl_if.start_of_packet[0] = 1'b0;
        ctrl_if.end_of_packet[0]   = 1'b0;
        check("vc0_single_no_active", 32'(vc_active[0]), 32'h0);
        check("vc0_single_grant", 32'(ctrl_if.grant[0]), 32'h1);
        flit_sent[0]     = 1'b1;
        credit_return[0] = 1'b1;
        ctrl_if.free[0]    = 1'b1;
        ctrl_if.request[0] = 1'b0;
        cycle();
        clear_inputs();
        check("vc0_send_ret_same", 32'(cc(0)), 32'd4);
        check("vc0_freed", 32'(ctrl_if.grant[0]), 32'h0);

        // Protocol errors: free in GRANTED, SOP while ACTIVE, underflow.
        ctrl_if.request[1] = 1'b1;
        ctrl_if.request[3] = 1'b1;
        cycle();
        ctrl_if.free[1]            = 1'b1;
        ctrl_if.start_of_packet[3] = 1'b1;
        cycle();
        ctrl_if.free[1] = 1'b0;
        flit_sent[2]    = 1'b1;
        cycle(2);
        ctrl_if.start_of_packet[3] = 1'b0;
        flit_sent[2]               = 1'b0;
        check("errors_set", 32'(proto_error), 32'hE);
        cycle(3);
        check("errors_held", 32'(proto_error), 32'hE);
        check("vc3_mid_packet", 32'(vc_active[3]), 32'h1);

        // Reset in the middle of the VC3 packet.
        rst_n = 1'b0;
        cycle();
        check("rst_vc3_grant",  32'(ctrl_if.grant[3]), 32'h0);
        check("rst_vc3_active", 32'(vc_active[3]), 32'h0);
        check("rst_vc3_credit", 32'(cc(3)), 32'd4);
        check("rst_err_clear",  32'(proto_error), 32'h0);
        rst_n = 1'b1;
        clear_inputs();
        cycle();

        // Randomized traffic with periodic resets.
        for (int t = 0; t < 800; t++) begin
            rst_n = ($urandom_range(99) != 0);
            for (int i = 0; i < NCH; i++) begin
                ctrl_if.request[i]         = ($urandom_range(3) != 0);
                ctrl_if.free[i]            = ($urandom_range(7) == 0);
                ctrl_if.start_of_packet[i] = ($urandom_range(7) == 0);
                ctrl_if.end_of_packet[i]   = ($urandom_range(7) == 0);
                flit_sent[i]               = ($urandom_range(3) == 0);
                credit_return[i]           = ($urandom_range(3) == 0);
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
